scroll_bars: RTL and testbench
==============================

SCROLL_BARS -- requirements
Module: scroll_bars

Interface
REQ-001 Parameter NUM_BARS, default 20: number of history bars on screen.
REQ-002 Parameter BAR_PITCH, default 32: horizontal pixel distance between bar left edges.
REQ-003 Parameter BAR_W, default 28: bar width in pixels; BAR_W <= BAR_PITCH.
REQ-004 Parameter ORI_X, default 0: left edge of bar 0.
REQ-005 Parameter ORI_Y, default 150: baseline row; bars grow upward from ORI_Y-1.
REQ-006 Parameter UNIT_H, default 20: pixel height per level step.
REQ-007 Parameter NUM_CH, default 8: number of selectable channels.
REQ-008 Parameter LVL_W, default 3: bit width of each volume/frequency level.
REQ-009 Parameter PEAK_DECAY, default 4: number of shifts between one-step peak decays.
REQ-010 clk  input  1  system clock.
REQ-011 reset  input  1  reset; one clock, synchronous, active-high.
REQ-012 tick  input  1  scroll-timer enable; counter advances only on cycles with tick=1.
REQ-013 mode  input  1  0 = plain history, 1 = history plus peak-hold marker.
REQ-014 CounterX, CounterY  input  12 each  current pixel coordinates.
REQ-015 sel  input  $clog2(NUM_CH)  selected channel index.
REQ-016 play  input  NUM_CH  per-channel active flags.
REQ-017 vol_i, freq_i  input  NUM_CH*LVL_W each  channel k occupies bits [k*LVL_W +: LVL_W].
REQ-018 o_r, o_g, o_b  output  8 each  pixel colour.

Function
REQ-019 Block shall hold NUM_BARS entries {height level, palette index}; entry NUM_BARS-1 is newest, drawn rightmost.
REQ-020 Scroll counter cnt shall increment by 1 on each tick=1 cycle.
REQ-021 Shift event: tick=1 and cnt >= (2^LVL_W-1) - freq_lat; cnt then loads 0 the same cycle.
REQ-022 On shift, entry i shall take entry i+1 for i < NUM_BARS-1, and entry NUM_BARS-1 shall take {vol_lat, colour index}.
REQ-023 Colour index shall advance by 1 mod NUM_COLORS on every shift.
REQ-024 On shift, vol_lat/freq_lat shall load vol/freq of channel sel if play[sel]=1, else 0.
REQ-025 sel >= NUM_CH shall be treated as silent (vol/freq latch 0).
REQ-026 Bar i pixel hit: ORI_X+i*BAR_PITCH <= CounterX < ORI_X+i*BAR_PITCH+BAR_W and ORI_Y-level_i*UNIT_H <= CounterY < ORI_Y.
REQ-027 Height products shall be computed at 12-bit width; a negative top bound shall clamp to 0.
REQ-028 Level 0 shall draw nothing.
REQ-029 Peak register shall load vol_lat on a shift when vol_lat >= peak.
REQ-030 Otherwise peak shall decrement by 1, floor 0, on every PEAK_DECAY-th shift; the decay counter shall reset whenever peak reloads.
REQ-031 mode=1 shall draw a 2-row white marker at rows ORI_Y-peak*UNIT_H-2 .. -1 across all bar columns when peak>0.
REQ-032 In mode=1, the marker shall take priority over bar colour; mode shall not affect state updates.
REQ-033 Pixel output shall be registered with one clk latency from CounterX/CounterY to o_r/o_g/o_b.
REQ-034 A pixel with no hit shall output 0,0,0.
REQ-035 A tick coinciding with reset shall be ignored.

Reset
REQ-036 reset=1 at a clk edge shall clear cnt, vol_lat, freq_lat, peak, decay counter, colour index, all entries and o_r/o_g/o_b to 0, including mid-scroll.

Structure
REQ-037 Package screen_pkg shall hold rgb_t (8-bit r, g, b), NUM_COLORS, PALETTE (default {255,255,0}, {160,32,240}) and PEAK_RGB (white).
REQ-038 The entry shift register shall be sub-module bar_history, parameterised by NUM_BARS and entry width; the pixel compare stays in scroll_bars.

Verification
REQ-039 Reset, then tick held 1 with play=0 -> shift every 8 ticks; all pixels black; colour index still cycles.
REQ-040 sel=2, play[2]=1, vol ch2=5, freq ch2=7, tick=1 -> shift every cycle; after 1 shift, (X=608, Y=50) is yellow and (X=608, Y=49) is black; o_* changes 1 clk after the coordinate.
REQ-041 freq=0 -> 8-tick shift period; freq=4 -> 4-tick period; tick=0 cycles do not count.
REQ-042 mode=1: vol 6 then 0 sustained -> peak 6, decays to 5 after 4 shifts; marker rows 28..29 then 48..49.
REQ-043 sel=7 with NUM_CH=6 -> silent latch; reset asserted mid-scroll -> every entry and output 0 next cycle.
REQ-044 After 20 shifts, the first sample shall occupy bar 0; on the 21st shift it shall be discarded.

Source files
------------

// File: rtl/screen_pkg.sv
// Shared screen definitions for the scrolling bar display.
// Holds the pixel colour type, the bar palette, the peak-marker colour and a
// helper that turns a bar height into its top row.
package screen_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam int unsigned NUM_COLORS = 2;
    // Width of a palette index; kept at least 1 bit so a one-colour palette still works.
    localparam int unsigned CIDX_W = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;

    localparam rgb_t PALETTE [NUM_COLORS] = '{
        '{r: 8'd255, g: 8'd255, b: 8'd0},
        '{r: 8'd160, g: 8'd32,  b: 8'd240}
    };

    localparam rgb_t PEAK_RGB = '{r: 8'd255, g: 8'd255, b: 8'd255};

    // Top row of a bar standing on 'base' with pixel height 'height'.
    // A bar taller than the baseline clamps to row 0 instead of wrapping.
    function automatic logic [11:0] top_row(input logic [11:0] base, input logic [11:0] height);
        return (height > base) ? 12'd0 : base - height;
    endfunction

endpackage

// File: rtl/bar_history.sv
// Shift register of bar history entries.
// Ports:
//   clk, reset - clock, synchronous active-high reset (clears every entry)
//   shift      - move every entry one slot toward entry 0 and load din at the top
//   din        - new entry, lands in slot NUM_BARS-1 (newest)
//   entries    - all slots flattened; slot i at [i*ENTRY_W +: ENTRY_W]
module bar_history #(
    parameter int NUM_BARS = 20,
    parameter int ENTRY_W  = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        shift,
    input  logic [ENTRY_W-1:0]          din,
    output logic [NUM_BARS*ENTRY_W-1:0] entries
);

    logic [NUM_BARS*ENTRY_W-1:0] hist_q;

    // Oldest entry (slot 0) falls off the bottom on every shift.
    always_ff @(posedge clk) begin
        if (reset) begin
            hist_q <= '0;
        end else if (shift) begin
            hist_q <= {din, hist_q[NUM_BARS*ENTRY_W-1:ENTRY_W]};
        end
    end

    assign entries = hist_q;

endmodule

// File: rtl/scroll_bars.sv
// Scrolling volume-history bar display with optional peak-hold marker.
// Ports:
//   clk, reset         - clock, synchronous active-high reset
//   tick               - scroll timer enable; the scroll counter only advances on tick
//   mode               - 0: bars only, 1: bars plus white peak marker
//   CounterX, CounterY - current pixel coordinate
//   sel, play          - selected channel and per-channel active flags
//   vol_i, freq_i      - per-channel levels, channel k at [k*LVL_W +: LVL_W]
//   o_r, o_g, o_b      - pixel colour, registered one clock after the coordinate
module scroll_bars
    import screen_pkg::*;
#(
    parameter int NUM_BARS   = 20,
    parameter int BAR_PITCH  = 32,
    parameter int BAR_W      = 28,
    parameter int ORI_X      = 0,
    parameter int ORI_Y      = 150,
    parameter int UNIT_H     = 20,
    parameter int NUM_CH     = 8,
    parameter int LVL_W      = 3,
    parameter int PEAK_DECAY = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       mode,
    input  logic [11:0]                CounterX,
    input  logic [11:0]                CounterY,
    input  logic [$clog2(NUM_CH)-1:0]  sel,
    input  logic [NUM_CH-1:0]          play,
    input  logic [NUM_CH*LVL_W-1:0]    vol_i,
    input  logic [NUM_CH*LVL_W-1:0]    freq_i,
    output logic [7:0]                 o_r,
    output logic [7:0]                 o_g,
    output logic [7:0]                 o_b
);

    localparam int ENTRY_W = LVL_W + CIDX_W;
    localparam int DEC_W   = (PEAK_DECAY > 1) ? $clog2(PEAK_DECAY) : 1;
    localparam logic [LVL_W-1:0] MAX_LVL = '1;
    localparam logic [11:0]      ORI_Y12 = 12'(ORI_Y);

    logic [LVL_W-1:0]  cnt_q, vol_lat_q, freq_lat_q, peak_q;
    logic [DEC_W-1:0]  dcnt_q;
    logic [CIDX_W-1:0] cidx_q;
    logic [LVL_W-1:0]  vol_sel, freq_sel;
    logic              shift;
    logic [NUM_BARS*ENTRY_W-1:0] hist;
    rgb_t              pix, pix_q;

    // Selected channel; an out-of-range sel matches no channel and reads as silent.
    always_comb begin
        vol_sel  = '0;
        freq_sel = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (int'(sel) == k && play[k]) begin
                vol_sel  = vol_i[k*LVL_W +: LVL_W];
                freq_sel = freq_i[k*LVL_W +: LVL_W];
            end
        end
    end

    // Higher latched frequency lowers the threshold, i.e. scrolls faster.
    assign shift = tick && (cnt_q >= (MAX_LVL - freq_lat_q));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q      <= '0;
            vol_lat_q  <= '0;
            freq_lat_q <= '0;
            peak_q     <= '0;
            dcnt_q     <= '0;
            cidx_q     <= '0;
        end else if (shift) begin
            cnt_q      <= '0;
            vol_lat_q  <= vol_sel;
            freq_lat_q <= freq_sel;
            cidx_q     <= (cidx_q == CIDX_W'(NUM_COLORS - 1)) ? '0 : cidx_q + CIDX_W'(1);
            if (vol_lat_q >= peak_q) begin
                peak_q <= vol_lat_q;
                dcnt_q <= '0;
            end else if (dcnt_q == DEC_W'(PEAK_DECAY - 1)) begin
                dcnt_q <= '0;
                if (peak_q != '0) peak_q <= peak_q - LVL_W'(1);
            end else begin
                dcnt_q <= dcnt_q + DEC_W'(1);
            end
        end else if (tick) begin
            cnt_q <= cnt_q + LVL_W'(1);
        end
    end

    // Entry layout: {level, palette index}; the pushed entry uses the pre-shift latches.
    bar_history #(
        .NUM_BARS (NUM_BARS),
        .ENTRY_W  (ENTRY_W)
    ) u_hist (
        .clk     (clk),
        .reset   (reset),
        .shift   (shift),
        .din     ({vol_lat_q, cidx_q}),
        .entries (hist)
    );

    logic [LVL_W-1:0]  bar_lvl  [NUM_BARS];
    logic [CIDX_W-1:0] bar_cidx [NUM_BARS];
    logic [11:0]       bar_top  [NUM_BARS];
    logic [11:0]       peak_top;

    for (genvar i = 0; i < NUM_BARS; i++) begin : g_bar
        assign bar_lvl[i]  = hist[i*ENTRY_W + CIDX_W +: LVL_W];
        assign bar_cidx[i] = hist[i*ENTRY_W +: CIDX_W];
        assign bar_top[i]  = top_row(ORI_Y12, 12'(32'(bar_lvl[i]) * UNIT_H));
    end

    assign peak_top = top_row(ORI_Y12, 12'(32'(peak_q) * UNIT_H));

    logic col_hit, bar_hit, mark_hit;
    rgb_t bar_rgb;

    always_comb begin
        col_hit = 1'b0;
        bar_hit = 1'b0;
        bar_rgb = '0;
        for (int i = 0; i < NUM_BARS; i++) begin
            if ({1'b0, CounterX} >= 13'(ORI_X + i*BAR_PITCH) &&
                {1'b0, CounterX} <  13'(ORI_X + i*BAR_PITCH + BAR_W)) begin
                col_hit = 1'b1;
                if (bar_lvl[i] != '0 && CounterY >= bar_top[i] && CounterY < ORI_Y12) begin
                    bar_hit = 1'b1;
                    bar_rgb = PALETTE[bar_cidx[i]];
                end
            end
        end
        // Two rows directly above the peak height; a clamped top of 0 hides the marker.
        mark_hit = mode && (peak_q != '0) && col_hit && (CounterY < peak_top) &&
                   (({1'b0, CounterY} + 13'd2) >= {1'b0, peak_top});
        if (mark_hit)     pix = PEAK_RGB;
        else if (bar_hit) pix = bar_rgb;
        else              pix = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) pix_q <= '0;
        else       pix_q <= pix;
    end

    assign o_r = pix_q.r;
    assign o_g = pix_q.g;
    assign o_b = pix_q.b;

endmodule

// File: tb/tb_scroll_bars.sv
// Scoreboard bench for scroll_bars: probes push expected pixel colours,
// a monitor pops and compares one clock after each probed coordinate.
module tb_scroll_bars;

    localparam logic [23:0] K = 24'h000000;
    localparam logic [23:0] Y = 24'hFFFF00;
    localparam logic [23:0] P = 24'hA020F0;
    localparam logic [23:0] W = 24'hFFFFFF;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        mode = 1'b0;
    logic [11:0] CounterX = '0;
    logic [11:0] CounterY = '0;
    logic [2:0]  sel = '0;
    logic [5:0]  play = '0;
    logic [17:0] vol = '0;
    logic [17:0] freq = '0;
    logic [7:0]  o_r, o_g, o_b;

    logic        probe = 1'b0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        string       name;
        logic [23:0] rgb;
    } exp_t;
    exp_t exp_q[$];

    scroll_bars #(
        .NUM_CH (6)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .tick     (tick),
        .mode     (mode),
        .CounterX (CounterX),
        .CounterY (CounterY),
        .sel      (sel),
        .play     (play),
        .vol_i    (vol),
        .freq_i   (freq),
        .o_r      (o_r),
        .o_g      (o_g),
        .o_b      (o_b)
    );

    always #5 clk = ~clk;

    // Monitor: a probe registered at this edge is visible on o_* right after it.
    initial begin
        logic pend;
        exp_t e;
        forever begin
            @(posedge clk);
            pend = probe;
            #1;
            if (pend) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output got %h no expectation queued", {o_r, o_g, o_b});
                end else begin
                    e = exp_q.pop_front();
                    if ({o_r, o_g, o_b} !== e.rgb) begin
                        errors++;
                        $display("FAIL %s got %h expected %h", e.name, {o_r, o_g, o_b}, e.rgb);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "bench timed out");
    end

    task automatic probe_px(input int x, input int y, input logic [23:0] rgb, input string name);
        exp_t e;
        @(negedge clk);
        CounterX = 12'(x);
        CounterY = 12'(y);
        probe = 1'b1;
        e.name = name;
        e.rgb = rgb;
        exp_q.push_back(e);
    endtask

    task automatic probe_end();
        @(negedge clk);
        probe = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            tick = 1'b1;
        end
        @(negedge clk);
        tick = 1'b0;
    endtask

    // Tick is held high during reset to show it is ignored.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        tick = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        tick = 1'b0;
    endtask

    task automatic set_ch(input int k, input int v, input int f);
        vol[k*3 +: 3] = 3'(v);
        freq[k*3 +: 3] = 3'(f);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        probe_px(608, 149, K, "reset_b19");
        probe_px(0, 149, K, "reset_b0");
        probe_end();

        // Silent scrolling still advances the palette index.
        sel = 3'd2;
        set_ch(2, 5, 7);
        ticks(8);
        probe_px(608, 149, K, "silent_b19");
        probe_px(0, 149, K, "silent_b0");
        probe_end();
        play[2] = 1'b1;
        ticks(8);
        ticks(1);
        probe_px(608, 50, Y, "a_top_row");
        probe_px(608, 49, K, "a_above_top");
        probe_px(608, 50, Y, "a_top_again");
        probe_px(576, 50, K, "a_b18_empty");
        probe_end();
        ticks(1);
        probe_px(608, 50, P, "a_b19_purple");
        probe_px(603, 50, Y, "a_b18_right");
        probe_px(604, 50, K, "a_gap");
        probe_px(608, 150, K, "a_baseline");
        probe_px(635, 100, P, "a_b19_right");
        probe_px(636, 100, K, "a_past_b19");
        probe_end();

        // Shift period: freq 0 -> 8 ticks, freq 4 -> 4 ticks; idle cycles do not count.
        do_reset();
        sel = 3'd0;
        play = '1;
        set_ch(0, 3, 0);
        ticks(8);
        repeat (3) @(negedge clk);
        ticks(7);
        probe_px(608, 149, K, "b_no_shift_7");
        probe_end();
        set_ch(0, 3, 4);
        ticks(1);
        probe_px(608, 149, P, "b_shift_8");
        probe_px(608, 90, P, "b_lvl3_top");
        probe_px(608, 89, K, "b_lvl3_above");
        probe_end();
        ticks(2);
        repeat (2) @(negedge clk);
        ticks(1);
        probe_px(608, 149, P, "b_no_shift_3");
        probe_px(576, 149, K, "b_b18_empty");
        probe_end();
        ticks(1);
        probe_px(608, 149, Y, "b_shift_4");
        probe_px(576, 149, P, "b_b18_moved");
        probe_end();

        // First sample reaches bar 0 after 20 shifts, then drops out.
        do_reset();
        set_ch(0, 7, 7);
        ticks(8);
        set_ch(0, 1, 7);
        ticks(1);
        ticks(19);
        probe_px(0, 10, P, "c_b0_top");
        probe_px(0, 9, K, "c_b0_above");
        probe_px(32, 10, K, "c_b1_short");
        probe_px(32, 130, Y, "c_b1_lvl1");
        probe_px(32, 129, K, "c_b1_above");
        probe_end();
        ticks(1);
        probe_px(0, 10, K, "c_discarded");
        probe_px(0, 130, Y, "c_b0_next");
        probe_px(0, 129, K, "c_b0_next_above");
        probe_end();

        // Peak hold and decay.
        do_reset();
        mode = 1'b1;
        set_ch(0, 6, 7);
        ticks(8);
        set_ch(0, 0, 7);
        ticks(1);
        probe_px(0, 28, W, "d_mark_r28");
        probe_px(0, 29, W, "d_mark_r29");
        probe_px(0, 27, K, "d_mark_r27");
        probe_px(0, 30, K, "d_mark_r30");
        probe_px(28, 28, K, "d_mark_gap");
        probe_px(608, 29, W, "d_mark_over_bar");
        probe_px(608, 30, P, "d_bar_below");
        probe_end();
        ticks(3);
        probe_px(0, 28, W, "d_hold");
        probe_end();
        ticks(1);
        probe_px(0, 28, K, "d_old_mark_gone");
        probe_px(0, 48, W, "d_decay_r48");
        probe_px(0, 49, W, "d_decay_r49");
        probe_px(0, 47, K, "d_decay_r47");
        probe_end();
        mode = 1'b0;
        probe_px(0, 48, K, "d_mode0");
        probe_end();

        // Out-of-range select is silent; reset mid-scroll clears everything.
        do_reset();
        sel = 3'd7;
        vol = '1;
        freq = '1;
        ticks(16);
        probe_px(608, 149, K, "e_sel7_b19");
        probe_px(608, 10, K, "e_sel7_top");
        probe_end();
        sel = 3'd1;
        ticks(8);
        ticks(1);
        probe_px(608, 10, P, "e_sel1_b19");
        probe_end();
        ticks(3);
        begin
            exp_t e;
            @(negedge clk);
            reset = 1'b1;
            tick = 1'b1;
            CounterX = 12'd608;
            CounterY = 12'd10;
            probe = 1'b1;
            e.name = "e_reset_out";
            e.rgb = K;
            exp_q.push_back(e);
            @(negedge clk);
            reset = 1'b0;
            tick = 1'b0;
            e.name = "e_reset_entries";
            exp_q.push_back(e);
        end
        probe_px(576, 100, K, "e_reset_b18");
        probe_px(512, 100, K, "e_reset_b16");
        probe_end();
        ticks(8);
        ticks(1);
        probe_px(608, 10, P, "e_after_reset_b19");
        probe_px(576, 10, K, "e_after_reset_b18");
        probe_end();

        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pending_expectations got %0d outputs missing expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
